imm_gen_pipe: RTL and testbench



---
 rtl/imm_gen_pipe.sv | 183 ++++++++++++++++++
 tb/tb_imm_gen_pipe.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/imm_gen_pipe.sv
// imm_gen_pipe: decode-stage immediate generator with a valid/ready output buffer.
// The decode is purely combinational on the instruction word. Results are captured
// into an output register on accept. A skid register absorbs one extra entry while
// the consumer stalls, which keeps full throughput under back-pressure.
//
// Handshake: a transfer happens on a rising edge where valid && ready are both high.
// The producer holds instruction and in_valid until that edge. The block holds
// ext_immediate, imm_fmt and illegal stable while out_valid && !out_ready.
// Flush wins over any accept in the same cycle.
module imm_gen_pipe #(
  parameter int XLEN    = 32,
  parameter bit SKID_EN = 1'b1
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [31:0]     instruction,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] ext_immediate,
  output logic [2:0]      imm_fmt,
  output logic            illegal
);

  typedef enum logic [2:0] {
    FMT_R     = 3'd0,
    FMT_I     = 3'd1,
    FMT_S     = 3'd2,
    FMT_B     = 3'd3,
    FMT_U     = 3'd4,
    FMT_J     = 3'd5,
    FMT_SHAMT = 3'd6,
    FMT_ILL   = 3'd7
  } fmt_e;

  logic [6:0]      w_opcode;
  logic [2:0]      w_funct3;
  logic [31:0]     w_raw;     // immediate already sign/zero-extended to 32 bits
  fmt_e            w_fmt;
  logic            w_ill;
  logic [XLEN-1:0] w_imm;
  logic            w_accept;
  logic            w_out_free;

  logic            r_out_valid;
  logic [XLEN-1:0] r_out_imm;
  logic [2:0]      r_out_fmt;
  logic            r_out_ill;
  logic            r_skid_full;
  logic [XLEN-1:0] r_skid_imm;
  logic [2:0]      r_skid_fmt;
  logic            r_skid_ill;

  assign w_opcode = instruction[6:0];
  assign w_funct3 = instruction[14:12];

  // Decode opcode into format and a 32-bit extended immediate.
  always_comb begin
    w_raw = 32'd0;
    w_fmt = FMT_R;
    w_ill = 1'b0;
    case (w_opcode)
      7'b0000011, 7'b1100111, 7'b1110011: begin
        w_raw = {{20{instruction[31]}}, instruction[31:20]};
        w_fmt = FMT_I;
      end
      7'b0010011: begin
        if (w_funct3 == 3'b001 || w_funct3 == 3'b101) begin
          if (XLEN == 64) begin
            w_raw = {26'd0, instruction[25:20]};
            w_fmt = FMT_SHAMT;
          end else if (instruction[25]) begin
            // shamt >= 32 does not exist on a 32-bit datapath
            w_fmt = FMT_ILL;
            w_ill = 1'b1;
          end else begin
            w_raw = {27'd0, instruction[24:20]};
            w_fmt = FMT_SHAMT;
          end
        end else begin
          w_raw = {{20{instruction[31]}}, instruction[31:20]};
          w_fmt = FMT_I;
        end
      end
      7'b0011011: begin
        // OP-IMM-32 only exists on RV64
        if (XLEN == 64) begin
          w_raw = {{20{instruction[31]}}, instruction[31:20]};
          w_fmt = FMT_I;
        end else begin
          w_fmt = FMT_ILL;
          w_ill = 1'b1;
        end
      end
      7'b0100011: begin
        w_raw = {{20{instruction[31]}}, instruction[31:25], instruction[11:7]};
        w_fmt = FMT_S;
      end
      7'b1100011: begin
        w_raw = {{19{instruction[31]}}, instruction[31], instruction[7],
                 instruction[30:25], instruction[11:8], 1'b0};
        w_fmt = FMT_B;
      end
      7'b0110111, 7'b0010111: begin
        w_raw = {instruction[31:12], 12'd0};
        w_fmt = FMT_U;
      end
      7'b1101111: begin
        w_raw = {{11{instruction[31]}}, instruction[31], instruction[19:12],
                 instruction[20], instruction[30:21], 1'b0};
        w_fmt = FMT_J;
      end
      7'b0110011, 7'b0111011: begin
        w_fmt = FMT_R;
      end
      default: begin
        w_fmt = FMT_ILL;
        w_ill = 1'b1;
      end
    endcase
  end

  // Shamt values are zero-extended in w_raw, so a plain sign extension is correct for all formats.
  if (XLEN == 64) begin : g_ext64
    assign w_imm = {{32{w_raw[31]}}, w_raw};
  end else begin : g_ext32
    assign w_imm = w_raw;
  end

  if (SKID_EN) begin : g_ready_skid
    assign in_ready = !r_skid_full;
  end else begin : g_ready_single
    assign in_ready = !r_out_valid || out_ready;
  end

  assign w_accept   = in_valid && in_ready;
  assign w_out_free = !r_out_valid || out_ready;

  // Output register and skid register; skid always refills the output before new input.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_out_valid <= 1'b0;
      r_out_imm   <= '0;
      r_out_fmt   <= 3'd0;
      r_out_ill   <= 1'b0;
      r_skid_full <= 1'b0;
      r_skid_imm  <= '0;
      r_skid_fmt  <= 3'd0;
      r_skid_ill  <= 1'b0;
    end else if (flush) begin
      r_out_valid <= 1'b0;
      r_skid_full <= 1'b0;
    end else if (w_out_free) begin
      if (r_skid_full) begin
        r_out_valid <= 1'b1;
        r_out_imm   <= r_skid_imm;
        r_out_fmt   <= r_skid_fmt;
        r_out_ill   <= r_skid_ill;
        r_skid_full <= 1'b0;
      end else if (w_accept) begin
        r_out_valid <= 1'b1;
        r_out_imm   <= w_imm;
        r_out_fmt   <= w_fmt;
        r_out_ill   <= w_ill;
      end else begin
        r_out_valid <= 1'b0;
      end
    end else if (w_accept && SKID_EN) begin
      r_skid_full <= 1'b1;
      r_skid_imm  <= w_imm;
      r_skid_fmt  <= w_fmt;
      r_skid_ill  <= w_ill;
    end
  end

  assign out_valid     = r_out_valid;
  assign ext_immediate = r_out_imm;
  assign imm_fmt       = r_out_fmt;
  assign illegal       = r_out_ill;

endmodule

// File: tb/tb_imm_gen_pipe.sv
// Bench for imm_gen_pipe: a 32-bit and a 64-bit instance share every input,
// so one stimulus checks both widths against hand-computed expectations.
module tb_imm_gen_pipe;

  typedef struct {
    logic [31:0] instr;
    logic [31:0] imm32;
    logic [2:0]  fmt32;
    logic        ill32;
    logic [63:0] imm64;
    logic [2:0]  fmt64;
    logic        ill64;
  } vec_t;

  logic        clk;
  logic        rst_n;
  logic        flush;
  logic        in_valid;
  logic [31:0] instruction;
  logic        out_ready;

  logic        rdy32, vld32, ill32;
  logic [31:0] imm32;
  logic [2:0]  fmt32;
  logic        rdy64, vld64, ill64;
  logic [63:0] imm64;
  logic [2:0]  fmt64;

  int n_vec;
  int n_bad;
  vec_t vq[$];

  imm_gen_pipe #(.XLEN(32), .SKID_EN(1'b1)) u_dut32 (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .in_valid(in_valid), .in_ready(rdy32), .instruction(instruction),
    .out_valid(vld32), .out_ready(out_ready),
    .ext_immediate(imm32), .imm_fmt(fmt32), .illegal(ill32)
  );

  imm_gen_pipe #(.XLEN(64), .SKID_EN(1'b1)) u_dut64 (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .in_valid(in_valid), .in_ready(rdy64), .instruction(instruction),
    .out_valid(vld64), .out_ready(out_ready),
    .ext_immediate(imm64), .imm_fmt(fmt64), .illegal(ill64)
  );

  // Clock
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  task automatic add(input logic [31:0] i,
                     input logic [31:0] m32, input logic [2:0] f32, input logic l32,
                     input logic [63:0] m64, input logic [2:0] f64, input logic l64);
    vec_t v;
    v.instr = i;
    v.imm32 = m32; v.fmt32 = f32; v.ill32 = l32;
    v.imm64 = m64; v.fmt64 = f64; v.ill64 = l64;
    vq.push_back(v);
  endtask

  // Both instances must present table entry idx as a valid output.
  task automatic chk_out(input string name, input int idx);
    chk({name, "_valid32"}, {63'd0, vld32}, 64'd1);
    chk({name, "_imm32"},   {32'd0, imm32}, {32'd0, vq[idx].imm32});
    chk({name, "_fmt32"},   {61'd0, fmt32}, {61'd0, vq[idx].fmt32});
    chk({name, "_ill32"},   {63'd0, ill32}, {63'd0, vq[idx].ill32});
    chk({name, "_valid64"}, {63'd0, vld64}, 64'd1);
    chk({name, "_imm64"},   imm64,          vq[idx].imm64);
    chk({name, "_fmt64"},   {61'd0, fmt64}, {61'd0, vq[idx].fmt64});
    chk({name, "_ill64"},   {63'd0, ill64}, {63'd0, vq[idx].ill64});
  endtask

  task automatic chk_empty(input string name);
    chk({name, "_valid32"}, {63'd0, vld32}, 64'd0);
    chk({name, "_valid64"}, {63'd0, vld64}, 64'd0);
    chk({name, "_rdy32"},   {63'd0, rdy32}, 64'd1);
    chk({name, "_rdy64"},   {63'd0, rdy64}, 64'd1);
  endtask

  task automatic chk_ready(input string name, input logic exp);
    chk({name, "_rdy32"}, {63'd0, rdy32}, {63'd0, exp});
    chk({name, "_rdy64"}, {63'd0, rdy64}, {63'd0, exp});
  endtask

  task automatic chk_cleared(input string name);
    chk_empty(name);
    chk({name, "_imm32"}, {32'd0, imm32}, 64'd0);
    chk({name, "_fmt32"}, {61'd0, fmt32}, 64'd0);
    chk({name, "_ill32"}, {63'd0, ill32}, 64'd0);
    chk({name, "_imm64"}, imm64, 64'd0);
    chk({name, "_fmt64"}, {61'd0, fmt64}, 64'd0);
    chk({name, "_ill64"}, {63'd0, ill64}, 64'd0);
  endtask

  // Single transfer with out_ready high, checked one cycle after the accept edge.
  task automatic send_one(input string name, input int idx);
    @(negedge clk);
    in_valid    = 1'b1;
    instruction = vq[idx].instr;
    @(negedge clk);
    in_valid = 1'b0;
    chk_out(name, idx);
  endtask

  initial begin
    rst_n       = 1'b0;
    flush       = 1'b0;
    in_valid    = 1'b0;
    instruction = 32'd0;
    out_ready   = 1'b1;
    n_vec       = 0;
    n_bad       = 0;

    //   instr          imm32          f  il  imm64                  f  il
    add(32'hFFF00093, 32'hFFFFFFFF, 3'd1, 1'b0, 64'hFFFFFFFFFFFFFFFF, 3'd1, 1'b0); // 0 addi -1
    add(32'hFE112E23, 32'hFFFFFFFC, 3'd2, 1'b0, 64'hFFFFFFFFFFFFFFFC, 3'd2, 1'b0); // 1 sw -4
    add(32'hFE000CE3, 32'hFFFFFFF8, 3'd3, 1'b0, 64'hFFFFFFFFFFFFFFF8, 3'd3, 1'b0); // 2 beq -8
    add(32'h123450B7, 32'h12345000, 3'd4, 1'b0, 64'h0000000012345000, 3'd4, 1'b0); // 3 lui
    add(32'h0010006F, 32'h00000800, 3'd5, 1'b0, 64'h0000000000000800, 3'd5, 1'b0); // 4 jal +2048
    add(32'h0000007F, 32'h00000000, 3'd7, 1'b1, 64'h0000000000000000, 3'd7, 1'b1); // 5 bad opcode
    add(32'h02009093, 32'h00000000, 3'd7, 1'b1, 64'h0000000000000020, 3'd6, 1'b0); // 6 slli 32
    add(32'h03F09093, 32'h00000000, 3'd7, 1'b1, 64'h000000000000003F, 3'd6, 1'b0); // 7 slli 63
    add(32'h00509093, 32'h00000005, 3'd6, 1'b0, 64'h0000000000000005, 3'd6, 1'b0); // 8 slli 5
    add(32'hFFF0809B, 32'h00000000, 3'd7, 1'b1, 64'hFFFFFFFFFFFFFFFF, 3'd1, 1'b0); // 9 addiw -1
    add(32'h002081B3, 32'h00000000, 3'd0, 1'b0, 64'h0000000000000000, 3'd0, 1'b0); // 10 add
    add(32'h80000017, 32'h80000000, 3'd4, 1'b0, 64'hFFFFFFFF80000000, 3'd4, 1'b0); // 11 auipc
    add(32'h7FF00067, 32'h000007FF, 3'd1, 1'b0, 64'h00000000000007FF, 3'd1, 1'b0); // 12 jalr
    add(32'h00002003, 32'h00000000, 3'd1, 1'b0, 64'h0000000000000000, 3'd1, 1'b0); // 13 lw 0
    add(32'h00100073, 32'h00000001, 3'd1, 1'b0, 64'h0000000000000001, 3'd1, 1'b0); // 14 ebreak
    add(32'h80000FEF, 32'hFFF00000, 3'd5, 1'b0, 64'hFFFFFFFFFFF00000, 3'd5, 1'b0); // 15 jal min
    add(32'h00000463, 32'h00000008, 3'd3, 1'b0, 64'h0000000000000008, 3'd3, 1'b0); // 16 beq +8

    // Reset state
    repeat (2) @(negedge clk);
    chk_cleared("in_reset");
    rst_n = 1'b1;
    @(negedge clk);
    chk_cleared("after_reset");

    // Table-driven single transfers
    for (int k = 0; k < vq.size(); k++) begin
      send_one($sformatf("vec%0d", k), k);
    end
    @(negedge clk);
    chk_empty("table_drain");

    // Back-to-back stream of entries 1..4, one per cycle
    @(negedge clk);
    in_valid    = 1'b1;
    instruction = vq[1].instr;
    for (int k = 1; k <= 4; k++) begin
      @(negedge clk);
      chk_out($sformatf("b2b%0d", k), k);
      chk_ready($sformatf("b2b%0d", k), 1'b1);
      if (k < 4) instruction = vq[k + 1].instr;
      else       in_valid = 1'b0;
    end
    @(negedge clk);
    chk_empty("b2b_drain");

    // Back-pressure: A at output, B in skid, C stalled, then drain in order
    out_ready   = 1'b0;
    in_valid    = 1'b1;
    instruction = vq[1].instr;
    @(negedge clk);
    chk_out("bp_a_first", 1);
    instruction = vq[2].instr;
    @(negedge clk);
    chk_out("bp_a_hold", 1);
    chk_ready("bp_skid_full", 1'b0);
    instruction = vq[3].instr;
    @(negedge clk);
    chk_out("bp_a_stall", 1);
    chk_ready("bp_c_stalled", 1'b0);
    out_ready = 1'b1;
    @(negedge clk);
    chk_out("bp_b", 2);
    chk_ready("bp_skid_freed", 1'b1);
    @(negedge clk);
    chk_out("bp_c", 3);
    in_valid = 1'b0;
    @(negedge clk);
    chk_empty("bp_drain");

    // Flush with skid full and a competing in_valid
    out_ready   = 1'b0;
    in_valid    = 1'b1;
    instruction = vq[1].instr;
    @(negedge clk);
    instruction = vq[2].instr;
    @(negedge clk);
    instruction = vq[3].instr;
    flush       = 1'b1;
    @(negedge clk);
    flush    = 1'b0;
    in_valid = 1'b0;
    chk_empty("flush");
    chk("flush_keep_imm32", {32'd0, imm32}, {32'd0, vq[1].imm32});
    out_ready = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk_empty($sformatf("flush_quiet%0d", k));
    end
    send_one("post_flush", 4);

    // Asynchronous reset mid-stream
    out_ready   = 1'b0;
    @(negedge clk);
    in_valid    = 1'b1;
    instruction = vq[11].instr;
    @(negedge clk);
    instruction = vq[15].instr;
    @(negedge clk);
    in_valid = 1'b0;
    chk_ready("pre_reset_full", 1'b0);
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk_cleared("async_reset");
    @(negedge clk);
    rst_n     = 1'b1;
    out_ready = 1'b1;
    send_one("post_reset", 0);
    @(negedge clk);
    chk_empty("final_drain");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
